// File: rtl/branch_redirect_unit.sv
// ---------------------------------------------------------------------------
// branch_redirect_unit
//
// Purpose:
//   Turns a resolved EX-stage branch or jump into a PC redirect and pipeline
//   flushes. If fetch cannot take the PC load (if_ready=0), the halfword-
//   aligned target is held in a pending register. The unit then waits in
//   PENDING until fetch is ready.
//
// Configuration:
//   BRANCH_STATS_EN - when defined, builds saturating 32-bit counters for
//                     resolved branches and taken branches/jumps. When the
//                     macro is not defined, both statistics outputs are
//                     tied to 0.
//
// Ports:
//   clk, reset     - clock and synchronous active-high reset
//   ex_valid       - EX stage holds a live instruction
//   ex_is_branch   - EX instruction is a conditional branch
//   ex_is_jump     - EX instruction is jal/jalr
//   Branch         - branch condition result
//   ex_target      - computed target address (bit 0 is discarded)
//   if_ready       - fetch accepts a PC load this cycle
//   pc_redirect    - load redirect_pc into the PC
//   redirect_pc    - redirect address (bit 0 always 0)
//   flush_fd       - squash IF/ID
//   flush_de       - squash ID/EX
//   busy           - a redirect is pending
//   stat_branches  - resolved branch count
//   stat_taken     - taken branch/jump count
// ---------------------------------------------------------------------------
module branch_redirect_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_is_jump,
  input  logic        Branch,
  input  logic [31:0] ex_target,
  input  logic        if_ready,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        flush_fd,
  output logic        flush_de,
  output logic        busy,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_taken
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pend_q, pend_d;
  logic        take_s;
  logic [31:0] tgt_s;

  // A jump wins over a simultaneous branch flag, so branch+jump always counts as taken.
  assign take_s = ex_valid & (ex_is_jump | (ex_is_branch & Branch));
  assign tgt_s  = {ex_target[31:1], 1'b0};

  // Next-state logic and redirect/flush outputs.
  // These outputs are combinational: a ready fetch must see the redirect in the same cycle.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pc_redirect = 1'b0;
    redirect_pc = 32'h0000_0000;
    flush_fd    = 1'b0;
    flush_de    = 1'b0;
    busy        = 1'b0;
    if (reset) begin
      state_d = IDLE;
      pend_d  = 32'h0000_0000;
    end else begin
      case (state_q)
        IDLE: begin
          redirect_pc = tgt_s;
          if (take_s) begin
            flush_fd    = 1'b1;
            flush_de    = 1'b1;
            pc_redirect = if_ready;
            if (!if_ready) begin
              state_d = PENDING;
              pend_d  = tgt_s;
            end else begin
              state_d = IDLE;
            end
          end else begin
            state_d = IDLE;
          end
        end
        PENDING: begin
          // New takes are ignored here.
          // The wrong-path instruction in IF/ID is squashed by holding flush_fd high.
          busy        = 1'b1;
          redirect_pc = pend_q;
          pc_redirect = if_ready;
          flush_fd    = 1'b1;
          if (if_ready) begin
            state_d = IDLE;
          end else begin
            state_d = PENDING;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and pending-target registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_taken_q;

  // Saturating statistics counters; they only count while IDLE, so events ignored in PENDING are not counted
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches_q <= 32'h0000_0000;
      stat_taken_q    <= 32'h0000_0000;
    end else begin
      if ((state_q == IDLE) && ex_valid && ex_is_branch &&
          (stat_branches_q != 32'hFFFF_FFFF)) begin
        stat_branches_q <= stat_branches_q + 32'd1;
      end else begin
        stat_branches_q <= stat_branches_q;
      end
      if ((state_q == IDLE) && take_s && (stat_taken_q != 32'hFFFF_FFFF)) begin
        stat_taken_q <= stat_taken_q + 32'd1;
      end else begin
        stat_taken_q <= stat_taken_q;
      end
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_taken    = stat_taken_q;
`else
  assign stat_branches = 32'h0000_0000;
  assign stat_taken    = 32'h0000_0000;
`endif

endmodule

// File: doc/branch_redirect_unit.md
BRANCH_REDIRECT_UNIT -- requirements
Module: branch_redirect_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset. All state SHALL update on the rising edge of `clk`.
REQ-002 Port list:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `ex_valid` in 1: the EX stage holds a live instruction.
- `ex_is_branch` in 1: the EX instruction is a conditional branch.
- `ex_is_jump` in 1: the EX instruction is jal or jalr.
- `Branch` in 1: branch-condition result from the EX-stage branch logic.
- `ex_target` in 32: computed target address.
- `if_ready` in 1: fetch accepts a PC load this cycle (0 while instruction-memory is stalled).
- `pc_redirect` out 1: load `redirect_pc` into the PC.
- `redirect_pc` out 32: redirect address.
- `flush_fd` out 1: squash the IF/ID register.
- `flush_de` out 1: squash the ID/EX register.
- `busy` out 1: a redirect is pending.
- `stat_branches` out 32: count of resolved branches.
- `stat_taken` out 32: count of taken branches and jumps.

Function
REQ-003 take SHALL equal `ex_valid & (ex_is_jump | (ex_is_branch & Branch))`.
REQ-004 The FSM SHALL have exactly two states, IDLE and PENDING.
REQ-005 In IDLE, when take=1 and `if_ready`=1, the same cycle SHALL combinationally assert `pc_redirect`, `flush_fd` and `flush_de`, drive `redirect_pc`={`ex_target`[31:1],0}, and stay in IDLE.
REQ-006 In IDLE, when take=1 and `if_ready`=0, that cycle SHALL:
- assert `flush_fd` and `flush_de`;
- keep `pc_redirect`=0;
- latch {`ex_target`[31:1],0} into the pending register;
- go to PENDING at the next edge.
REQ-007 In PENDING, `busy`=1 and `redirect_pc` SHALL equal the pending register.
- `pc_redirect` SHALL equal `if_ready`.
- `flush_fd` SHALL be 1 every cycle.
- `flush_de` SHALL be 0.
- The state SHALL return to IDLE at the edge where `if_ready`=1.
REQ-008 In PENDING, take SHALL be ignored: no new latch, no counter update. The wrong-path instruction is squashed by `flush_fd`.
REQ-009 When take=0 in IDLE, `pc_redirect`, `flush_fd`, `flush_de` and `busy` SHALL be 0. `redirect_pc` SHALL be {`ex_target`[31:1],0} (don't-care for consumers).
REQ-010 Simultaneous `ex_is_branch` and `ex_is_jump` SHALL be treated as a jump (taken).
REQ-011 Redirect latency from take to PC load SHALL be 0 cycles when `if_ready`=1, else the number of cycles until `if_ready` rises.
REQ-012 Bit 0 of every `redirect_pc` SHALL be 0; `ex_target`[0] SHALL be discarded.

Reset
REQ-013 When `reset`=1 at an edge, the block SHALL take these values regardless of state, including mid-PENDING:
- state=IDLE;
- pending register=0;
- both counters=0.
REQ-014 While `reset` is asserted, all 1-bit outputs SHALL be 0 and `redirect_pc` SHALL be 0.
REQ-015 A pending redirect aborted by reset SHALL never be issued.

Configuration
REQ-016 With macro `BRANCH_STATS_EN` defined, the statistics counters SHALL be built:
- `stat_branches` increments at each edge where `ex_valid & ex_is_branch` and the state is IDLE;
- `stat_taken` increments at each edge where take=1 and the state is IDLE;
- both counters saturate at 32'hFFFFFFFF.
REQ-017 Without `BRANCH_STATS_EN`, `stat_branches` and `stat_taken` SHALL be constant 0 and no counter registers SHALL exist. All other behaviour SHALL be identical.

Verification
REQ-018 IDLE, `ex_valid`=1, `ex_is_branch`=1, `Branch`=1, `ex_target`=0x0000_0104, `if_ready`=1 -> same cycle `pc_redirect`=1, `redirect_pc`=0x104, `flush_fd`=`flush_de`=1; next cycle all 0.
REQ-019 Branch with `Branch`=0 -> `pc_redirect`=`flush_fd`=`flush_de`=0. With the macro, `stat_branches`+1 and `stat_taken` unchanged.
REQ-020 jalr, `ex_target`=0x0000_2003, `if_ready`=0 for 3 cycles:
- cycle 0: flushes=1, `pc_redirect`=0;
- cycles 1-2: `busy`=1, `flush_fd`=1;
- cycle 3 (`if_ready`=1): `pc_redirect`=1, `redirect_pc`=0x2002;
- cycle 4: IDLE.
REQ-021 Taken branch to 0x300 presented while PENDING with target 0x200 -> 0x300 is ignored, the redirect goes to 0x200, and the counters are unchanged by the ignored event.
REQ-022 `reset` asserted in PENDING -> next cycle IDLE, `busy`=0, `pc_redirect` never asserted for the pending target, counters=0.
REQ-023 With the macro, counters forced near 0xFFFFFFFF (via 2^32 taken events or a bench force) -> values hold at 0xFFFFFFFF without wrapping. Without the macro, both outputs read 0 throughout.
